// File: rtl/spart_tx_fifo_if.sv
// Host-side bundle for spart_tx_fifo: write strobe/data, baud tick, status flags and TxD.
// Master is the host/bench side; slave is the transmitter.
`timescale 1ns/1ps
interface spart_tx_fifo_if #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 8
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic                 en;
    logic [DATA_BITS-1:0] data;
    logic                 en_tx;
    logic                 clr_ovf;
    logic                 tbr;
    logic                 full;
    logic                 empty;
    logic [CW-1:0]        count;
    logic                 busy;
    logic                 ovf;
    logic                 TxD;

    modport master (
        output en, data, en_tx, clr_ovf,
        input  tbr, full, empty, count, busy, ovf, TxD
    );

    modport slave (
        input  en, data, en_tx, clr_ovf,
        output tbr, full, empty, count, busy, ovf, TxD
    );
endinterface

// File: rtl/spart_tx_fifo.sv
// Queued UART transmitter: FIFO of host bytes serialised on TxD with start/data/parity/stop bits.
// Latency: flags 1 clk after a write; TxD falls 1 clk after the first write into an idle, empty queue.
// Backpressure: tbr = ~full; a write into a full FIFO is dropped and latches ovf until clr_ovf.
`timescale 1ns/1ps
module spart_tx_fifo #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic            clk,
    input  logic            rst,
    spart_tx_fifo_if.slave  bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam bit BAD_PARAM = (DATA_BITS < 5) || (DATA_BITS > 8) ||
                               (PARITY < 0) || (PARITY > 2) ||
                               ((STOP_BITS != 1) && (STOP_BITS != 2)) ||
                               (FIFO_DEPTH < 2) || (FIFO_DEPTH > 64) ||
                               ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0);

    if (BAD_PARAM) begin : g_bad_param
        $error("spart_tx_fifo: illegal DATA_BITS/PARITY/STOP_BITS/FIFO_DEPTH");
    end

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

    logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]        r_wr_ptr, r_rd_ptr;
    logic [CW-1:0]        r_count;
    logic                 r_ovf;
    state_t               r_state, w_state_nxt;
    logic [TW-1:0]        r_tick, w_tick_nxt;
    logic [3:0]           r_bit, w_bit_nxt;
    logic [DATA_BITS-1:0] r_shift, w_shift_nxt;
    logic                 r_par, w_par_nxt;
    logic                 r_txd, w_txd_nxt;
    logic                 w_pop, w_wr, w_drop, w_full, w_empty, w_bit_end;
    logic [DATA_BITS-1:0] w_head;

    assign w_full    = (r_count == CW'(FIFO_DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_wr      = bus.en_tx & ~w_full;
    assign w_drop    = bus.en_tx & w_full;
    assign w_head    = r_mem[r_rd_ptr];
    assign w_bit_end = bus.en & (r_tick == TW'(OVERSAMPLE - 1));

    always_comb begin
        w_state_nxt = r_state;
        w_tick_nxt  = r_tick;
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        w_par_nxt   = r_par;
        w_txd_nxt   = r_txd;
        w_pop       = 1'b0;
        if (r_state != S_IDLE && bus.en)
            w_tick_nxt = w_bit_end ? '0 : r_tick + TW'(1);
        case (r_state)
            S_IDLE: begin
                w_txd_nxt = 1'b1;
                w_pop     = ~w_empty;
            end
            S_START: if (w_bit_end) begin
                w_state_nxt = S_DATA;
                w_txd_nxt   = r_shift[0];
                w_shift_nxt = r_shift >> 1;
                w_bit_nxt   = '0;
            end
            S_DATA: if (w_bit_end) begin
                if (r_bit == 4'(DATA_BITS - 1)) begin
                    w_bit_nxt = '0;
                    if (PARITY != 0) begin
                        w_state_nxt = S_PAR;
                        w_txd_nxt   = r_par;
                    end else begin
                        w_state_nxt = S_STOP;
                        w_txd_nxt   = 1'b1;
                    end
                end else begin
                    w_bit_nxt   = r_bit + 4'd1;
                    w_txd_nxt   = r_shift[0];
                    w_shift_nxt = r_shift >> 1;
                end
            end
            S_PAR: if (w_bit_end) begin
                w_state_nxt = S_STOP;
                w_txd_nxt   = 1'b1;
            end
            S_STOP: if (w_bit_end) begin
                // Chain straight into the next start bit when more data is queued.
                if (r_bit == 4'(STOP_BITS - 1)) begin
                    if (!w_empty) w_pop = 1'b1;
                    else          w_state_nxt = S_IDLE;
                end else begin
                    w_bit_nxt = r_bit + 4'd1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (w_pop) begin
            w_state_nxt = S_START;
            w_txd_nxt   = 1'b0;
            w_tick_nxt  = '0;
            w_bit_nxt   = '0;
            w_shift_nxt = w_head;
            w_par_nxt   = (^w_head) ^ (PARITY == 2);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_tick   <= '0;
            r_bit    <= '0;
            r_shift  <= '0;
            r_par    <= 1'b0;
            r_txd    <= 1'b1;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_tick  <= w_tick_nxt;
            r_bit   <= w_bit_nxt;
            r_shift <= w_shift_nxt;
            r_par   <= w_par_nxt;
            r_txd   <= w_txd_nxt;
            if (w_wr)  r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= r_count + CW'(w_wr) - CW'(w_pop);
            if (w_drop)           r_ovf <= 1'b1;
            else if (bus.clr_ovf) r_ovf <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr_ptr] <= bus.data;
    end

    assign bus.tbr   = ~w_full;
    assign bus.full  = w_full;
    assign bus.empty = w_empty;
    assign bus.count = r_count;
    assign bus.busy  = (r_state != S_IDLE);
    assign bus.ovf   = r_ovf;
    assign bus.TxD   = r_txd;
endmodule

// File: tb/tb_spart_tx_fifo.sv
// Bench for spart_tx_fifo: 8N1 main instance plus 7E2 and 8O1 instances, en tied high except
// during the queue-fill table; expected waveforms and byte order come from a frame-level model.
`timescale 1ns/1ps
module tb_spart_tx_fifo;
    localparam int OS = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    spart_tx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(8)) u_if ();
    spart_tx_fifo_if #(.DATA_BITS(7), .FIFO_DEPTH(4)) u_if_7e2 ();
    spart_tx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(4)) u_if_8o1 ();

    spart_tx_fifo #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(8), .OVERSAMPLE(OS))
        u_dut (.clk(clk), .rst(rst_n), .bus(u_if));
    spart_tx_fifo #(.DATA_BITS(7), .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(4), .OVERSAMPLE(OS))
        u_dut_7e2 (.clk(clk), .rst(rst_n), .bus(u_if_7e2));
    spart_tx_fifo #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4), .OVERSAMPLE(OS))
        u_dut_8o1 (.clk(clk), .rst(rst_n), .bus(u_if_8o1));

    typedef struct {
        logic       en_tx;
        logic [7:0] data;
        logic       clr_ovf;
        logic [3:0] count;
        logic       full;
        logic       ovf;
        logic       busy;
        logic       txd;
    } vec_t;

    int         n_cmp = 0;
    int         n_fail = 0;
    logic [7:0] exp_q[$];
    logic       exp_wave[$];
    logic [7:0] nextv = 8'h20;
    vec_t       vt[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic get_txd(input int sel);
        case (sel)
            0:       return u_if.TxD;
            1:       return u_if_7e2.TxD;
            default: return u_if_8o1.TxD;
        endcase
    endfunction

    task automatic write1(input int sel, input logic [7:0] d);
        case (sel)
            0: begin u_if.data = d;          u_if.en_tx = 1'b1;     cyc(); u_if.en_tx = 1'b0;     end
            1: begin u_if_7e2.data = d[6:0]; u_if_7e2.en_tx = 1'b1; cyc(); u_if_7e2.en_tx = 1'b0; end
            default: begin u_if_8o1.data = d; u_if_8o1.en_tx = 1'b1; cyc(); u_if_8o1.en_tx = 1'b0; end
        endcase
    endtask

    // Frame model: start, nb data bits LSB first, optional parity, sb stop bits; OS samples each.
    task automatic add_frame(input logic [7:0] d, input int nb, input int par, input int sb);
        logic p;
        p = (par == 2);
        for (int r = 0; r < OS; r++) exp_wave.push_back(1'b0);
        for (int i = 0; i < nb; i++) begin
            p ^= d[i];
            for (int r = 0; r < OS; r++) exp_wave.push_back(d[i]);
        end
        if (par != 0)
            for (int r = 0; r < OS; r++) exp_wave.push_back(p);
        for (int s = 0; s < sb * OS; s++) exp_wave.push_back(1'b1);
    endtask

    task automatic check_wave(input int sel, input string name);
        int bad;
        bad = 0;
        for (int k = 0; k < exp_wave.size(); k++) begin
            if (get_txd(sel) !== exp_wave[k]) bad++;
            cyc();
        end
        check(name, bad, 0);
        exp_wave.delete();
    endtask

    task automatic rx_frames(input int n, input bit start_now);
        logic [7:0] d;
        logic [7:0] e;
        int         framing;
        framing = 0;
        for (int f = 0; f < n; f++) begin
            if (!(start_now && f == 0)) begin
                int k;
                k = 0;
                while (u_if.TxD !== 1'b0 && k < 4000) begin cyc(); k++; end
                if (u_if.TxD !== 1'b0) begin
                    check("rx_start_timeout", u_if.TxD, 0);
                    return;
                end
            end
            repeat (OS / 2) cyc();
            if (u_if.TxD !== 1'b0) framing++;
            for (int b = 0; b < 8; b++) begin
                repeat (OS) cyc();
                d[b] = u_if.TxD;
            end
            repeat (OS) cyc();
            if (u_if.TxD !== 1'b1) framing++;
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
            check("rx_byte", d, e);
        end
        check("rx_framing_errors", framing, 0);
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (u_if.busy !== 1'b0 && k < 400) begin cyc(); k++; end
        check("idle_busy", u_if.busy, 0);
        check("idle_empty", u_if.empty, 1);
    endtask

    task automatic run_burst(input int n, input int gapmax, input bit incr);
        logic [7:0] vals[9];
        for (int i = 0; i < n; i++) begin
            vals[i] = incr ? nextv : 8'($urandom);
            if (incr) nextv = nextv + 8'd1;
            exp_q.push_back(vals[i]);
        end
        fork
            begin
                for (int i = 0; i < n; i++) begin
                    u_if.data  = vals[i];
                    u_if.en_tx = 1'b1;
                    cyc();
                    u_if.en_tx = 1'b0;
                    repeat ($urandom_range(gapmax, 0)) cyc();
                end
                cyc();
                // First byte left the queue at once; no frame completes within the burst.
                check("burst_count", u_if.count, n - 1);
                check("burst_full", u_if.full, (n - 1) == 8);
                check("burst_tbr", u_if.tbr, (n - 1) != 8);
                check("burst_empty", u_if.empty, (n - 1) == 0);
                check("burst_ovf", u_if.ovf, 0);
            end
            rx_frames(n, 1'b0);
        join
        wait_idle();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: time limit reached at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int lows;
        vt[0]  = '{1'b1, 8'h10, 1'b0, 4'd1, 1'b0, 1'b0, 1'b0, 1'b1};
        vt[1]  = '{1'b1, 8'h11, 1'b0, 4'd1, 1'b0, 1'b0, 1'b1, 1'b0};
        vt[2]  = '{1'b1, 8'h12, 1'b0, 4'd2, 1'b0, 1'b0, 1'b1, 1'b0};
        vt[3]  = '{1'b1, 8'h13, 1'b0, 4'd3, 1'b0, 1'b0, 1'b1, 1'b0};
        vt[4]  = '{1'b1, 8'h14, 1'b0, 4'd4, 1'b0, 1'b0, 1'b1, 1'b0};
        vt[5]  = '{1'b1, 8'h15, 1'b0, 4'd5, 1'b0, 1'b0, 1'b1, 1'b0};
        vt[6]  = '{1'b1, 8'h16, 1'b0, 4'd6, 1'b0, 1'b0, 1'b1, 1'b0};
        vt[7]  = '{1'b1, 8'h17, 1'b0, 4'd7, 1'b0, 1'b0, 1'b1, 1'b0};
        vt[8]  = '{1'b1, 8'h18, 1'b0, 4'd8, 1'b1, 1'b0, 1'b1, 1'b0};
        vt[9]  = '{1'b1, 8'h19, 1'b0, 4'd8, 1'b1, 1'b1, 1'b1, 1'b0};
        vt[10] = '{1'b0, 8'h00, 1'b1, 4'd8, 1'b1, 1'b0, 1'b1, 1'b0};
        vt[11] = '{1'b1, 8'hEE, 1'b1, 4'd8, 1'b1, 1'b1, 1'b1, 1'b0};
        vt[12] = '{1'b0, 8'h00, 1'b1, 4'd8, 1'b1, 1'b0, 1'b1, 1'b0};
        vt[13] = '{1'b0, 8'h00, 1'b0, 4'd8, 1'b1, 1'b0, 1'b1, 1'b0};

        u_if.en = 1'b0;     u_if.en_tx = 1'b0;     u_if.data = '0;     u_if.clr_ovf = 1'b0;
        u_if_7e2.en = 1'b1; u_if_7e2.en_tx = 1'b0; u_if_7e2.data = '0; u_if_7e2.clr_ovf = 1'b0;
        u_if_8o1.en = 1'b1; u_if_8o1.en_tx = 1'b0; u_if_8o1.data = '0; u_if_8o1.clr_ovf = 1'b0;
        rst_n = 1'b0;
        repeat (3) cyc();
        check("rst_txd", u_if.TxD, 1);
        check("rst_busy", u_if.busy, 0);
        check("rst_ovf", u_if.ovf, 0);
        check("rst_count", u_if.count, 0);
        check("rst_empty", u_if.empty, 1);
        check("rst_full", u_if.full, 0);
        check("rst_tbr", u_if.tbr, 1);
        check("rst_txd_7e2", u_if_7e2.TxD, 1);
        check("rst_txd_8o1", u_if_8o1.TxD, 1);
        rst_n = 1'b1;
        cyc();

        // Queue fill with en low: pop still happens, frame frozen in its start bit.
        for (int i = 0; i < 14; i++) begin
            u_if.en_tx   = vt[i].en_tx;
            u_if.data    = vt[i].data;
            u_if.clr_ovf = vt[i].clr_ovf;
            cyc();
            check($sformatf("tbl%0d_count", i), u_if.count, vt[i].count);
            check($sformatf("tbl%0d_full", i), u_if.full, vt[i].full);
            check($sformatf("tbl%0d_tbr", i), u_if.tbr, !vt[i].full);
            check($sformatf("tbl%0d_empty", i), u_if.empty, vt[i].count == 0);
            check($sformatf("tbl%0d_ovf", i), u_if.ovf, vt[i].ovf);
            check($sformatf("tbl%0d_busy", i), u_if.busy, vt[i].busy);
            check($sformatf("tbl%0d_txd", i), u_if.TxD, vt[i].txd);
        end
        u_if.en_tx = 1'b0;
        u_if.clr_ovf = 1'b0;
        for (int i = 0; i < 9; i++) exp_q.push_back(8'h10 + 8'(i));
        u_if.en = 1'b1;
        rx_frames(9, 1'b1);
        wait_idle();
        lows = 0;
        for (int k = 0; k < 200; k++) begin
            if (u_if.TxD !== 1'b1) lows++;
            cyc();
        end
        check("dropped_bytes_not_sent", lows, 0);

        // 8N1 single frame, exact waveform.
        add_frame(8'h40, 8, 0, 1);
        write1(0, 8'h40);
        check("8n1_txd_before_pop", u_if.TxD, 1);
        check("8n1_count_after_write", u_if.count, 1);
        cyc();
        check("8n1_busy_at_pop", u_if.busy, 1);
        check_wave(0, "wave_8n1_40");
        check("8n1_busy_end", u_if.busy, 0);

        // 7E2 and 8O1 parity frames.
        add_frame(8'h55, 7, 1, 2);
        write1(1, 8'h55);
        cyc();
        check_wave(1, "wave_7e2_55");
        check("7e2_busy_end", u_if_7e2.busy, 0);
        add_frame(8'h00, 8, 2, 1);
        write1(2, 8'h00);
        cyc();
        check_wave(2, "wave_8o1_00");
        check("8o1_busy_end", u_if_8o1.busy, 0);

        // Back-to-back frames: one stop bit between them, no idle gap.
        add_frame(8'hA5, 8, 0, 1);
        add_frame(8'h3C, 8, 0, 1);
        write1(0, 8'hA5);
        write1(0, 8'h3C);
        check_wave(0, "wave_b2b_a5_3c");
        check("b2b_busy_end", u_if.busy, 0);
        check("b2b_empty_end", u_if.empty, 1);

        // Reset in the middle of data bit 3.
        write1(0, 8'h00);
        write1(0, 8'h77);
        repeat (70) cyc();
        check("midrst_txd_before", u_if.TxD, 0);
        check("midrst_count_before", u_if.count, 1);
        rst_n = 1'b0;
        cyc();
        check("midrst_txd", u_if.TxD, 1);
        check("midrst_count", u_if.count, 0);
        check("midrst_busy", u_if.busy, 0);
        check("midrst_empty", u_if.empty, 1);
        rst_n = 1'b1;
        cyc();
        check("midrst_txd_after_release", u_if.TxD, 1);
        add_frame(8'h5A, 8, 0, 1);
        write1(0, 8'h5A);
        cyc();
        check_wave(0, "wave_after_reset_5a");
        check("after_reset_busy_end", u_if.busy, 0);

        // Pointer wrap: three full-queue rounds of incrementing bytes.
        for (int r = 0; r < 3; r++) run_burst(9, 0, 1'b1);

        // Randomised bursts against the byte-order model.
        for (int r = 0; r < 6; r++) run_burst($urandom_range(9, 1), 2, 1'b0);
        check("model_queue_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
